// File: rtl/quad_encoder_pkg.sv
// Decode constants and step classification for the quadrature encoder front end.
package quad_encoder_pkg;

    localparam logic [3:0] INC_A_RISE = 4'b1000;
    localparam logic [3:0] INC_A_FALL = 4'b0111;
    localparam logic [3:0] DEC_B_RISE = 4'b0010;
    localparam logic [3:0] DEC_B_FALL = 4'b1101;

    typedef enum logic [1:0] {
        STEP_HOLD = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2
    } step_e;

    // Classify {a_db, prev_a, b_db, prev_b}; simultaneous edges and idle codes hold.
    function automatic step_e decode_step(input logic [3:0] code);
        step_e step;
        step = STEP_HOLD;
        case (code)
            INC_A_RISE, INC_A_FALL: step = STEP_UP;
            DEC_B_RISE, DEC_B_FALL: step = STEP_DOWN;
            default:                step = STEP_HOLD;
        endcase
        return step;
    endfunction

endpackage

// File: rtl/contact_debounce.sv
// History-filter debouncer for one mechanical contact: the output changes only
// after HIST_LEN consecutive identical samples.
module contact_debounce #(
    parameter int unsigned HIST_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic db
);

    logic [HIST_LEN-1:0] hist;

    always_ff @(posedge clk) begin
        if (!reset) begin
            hist <= '0;
            db   <= 1'b0;
        end else begin
            hist <= {hist[HIST_LEN-2:0], in};
            if (&hist) begin
                db <= 1'b1;
            end else if (~|hist) begin
                db <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/quad_encoder_debounced.sv
// Debounced quadrature encoder with a wrapping up/down count.
// Define QENC_SYNC_EN to insert a 2-flop synchronizer on a and b ahead of the debounce.
module quad_encoder_debounced
    import quad_encoder_pkg::*;
#(
    parameter int unsigned HIST_LEN = 8,
    parameter int unsigned WIDTH    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    output logic             a_db,
    output logic             b_db,
    output logic             inc,
    output logic             dec,
    output logic [WIDTH-1:0] value
);

    logic  a_in;
    logic  b_in;
    logic  prev_a;
    logic  prev_b;
    step_e step_c;

`ifdef QENC_SYNC_EN
    logic [1:0] a_sync;
    logic [1:0] b_sync;

    // Two-stage synchronizers for asynchronous contact inputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_sync <= 2'b00;
            b_sync <= 2'b00;
        end else begin
            a_sync <= {a_sync[0], a};
            b_sync <= {b_sync[0], b};
        end
    end

    assign a_in = a_sync[1];
    assign b_in = b_sync[1];
`else
    assign a_in = a;
    assign b_in = b;
`endif

    contact_debounce #(.HIST_LEN(HIST_LEN)) u_db_a (
        .clk   (clk),
        .reset (reset),
        .in    (a_in),
        .db    (a_db)
    );

    contact_debounce #(.HIST_LEN(HIST_LEN)) u_db_b (
        .clk   (clk),
        .reset (reset),
        .in    (b_in),
        .db    (b_db)
    );

    always_comb begin
        step_c = decode_step({a_db, prev_a, b_db, prev_b});
    end

    // Edge history and modulo-2^WIDTH counter; inc/dec are one-cycle pulses
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_a <= 1'b0;
            prev_b <= 1'b0;
            inc    <= 1'b0;
            dec    <= 1'b0;
            value  <= '0;
        end else begin
            prev_a <= a_db;
            prev_b <= b_db;
            inc    <= (step_c == STEP_UP);
            dec    <= (step_c == STEP_DOWN);
            case (step_c)
                STEP_UP:   value <= value + WIDTH'(1);
                STEP_DOWN: value <= value - WIDTH'(1);
                default:   value <= value;
            endcase
        end
    end

endmodule

// File: tb/tb_quad_encoder_debounced.sv
// Directed, table-driven bench for quad_encoder_debounced (HIST_LEN=8, WIDTH=8).
module tb_quad_encoder_debounced;

    localparam int unsigned HIST_LEN = 8;
    localparam int unsigned WIDTH    = 8;
`ifdef QENC_SYNC_EN
    localparam int unsigned LAT = HIST_LEN + 4;
`else
    localparam int unsigned LAT = HIST_LEN + 2;
`endif
    localparam int unsigned NV   = 18;
    localparam int unsigned HOLD = 20;

    logic             clk;
    logic             reset;
    logic             a;
    logic             b;
    logic             a_db;
    logic             b_db;
    logic             inc;
    logic             dec;
    logic [WIDTH-1:0] value;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       a;
        logic       b;
        logic [7:0] exp_value;
        int         exp_inc;
        int         exp_dec;
    } vec_t;

    vec_t vecs [NV];

    quad_encoder_debounced #(.HIST_LEN(HIST_LEN), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .a_db  (a_db),
        .b_db  (b_db),
        .inc   (inc),
        .dec   (dec),
        .value (value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_inc;
        int n_dec;
        int n_both;
        int n_adb;
        int lat_seen;

        // a, b, expected value after settling, inc pulses, dec pulses
        vecs[0]  = '{1'b1, 1'b0, 8'h01, 1, 0};
        vecs[1]  = '{1'b1, 1'b1, 8'h01, 0, 0};
        vecs[2]  = '{1'b0, 1'b1, 8'h02, 1, 0};
        vecs[3]  = '{1'b0, 1'b0, 8'h02, 0, 0};
        vecs[4]  = '{1'b0, 1'b1, 8'h01, 0, 1};
        vecs[5]  = '{1'b1, 1'b1, 8'h01, 0, 0};
        vecs[6]  = '{1'b1, 1'b0, 8'h00, 0, 1};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 0, 0};
        vecs[8]  = '{1'b0, 1'b1, 8'hFF, 0, 1};
        vecs[9]  = '{1'b1, 1'b1, 8'hFF, 0, 0};
        vecs[10] = '{1'b1, 1'b0, 8'hFE, 0, 1};
        vecs[11] = '{1'b0, 1'b0, 8'hFE, 0, 0};
        vecs[12] = '{1'b1, 1'b0, 8'hFF, 1, 0};
        vecs[13] = '{1'b0, 1'b0, 8'hFF, 0, 0};
        vecs[14] = '{1'b1, 1'b0, 8'h00, 1, 0};
        vecs[15] = '{1'b0, 1'b0, 8'h00, 0, 0};
        vecs[16] = '{1'b1, 1'b1, 8'h00, 0, 0};
        vecs[17] = '{1'b0, 1'b0, 8'h00, 0, 0};

        // Reset held with both contacts high
        reset = 1'b0;
        a     = 1'b1;
        b     = 1'b1;
        repeat (3) tick();
        chk("reset_value", int'(value), 0);
        chk("reset_a_db", int'(a_db), 0);
        chk("reset_b_db", int'(b_db), 0);
        chk("reset_inc", int'(inc), 0);
        chk("reset_dec", int'(dec), 0);
        a = 1'b0;
        b = 1'b0;
        reset = 1'b1;
        repeat (HOLD) tick();

        // Bounces shorter than HIST_LEN never reach a_db
        for (int len = 1; len < int'(HIST_LEN); len++) begin
            n_adb = 0;
            n_inc = 0;
            a = 1'b1;
            repeat (len) begin
                tick();
                n_adb += int'(a_db);
                n_inc += int'(inc) + int'(dec);
            end
            a = 1'b0;
            repeat (16) begin
                tick();
                n_adb += int'(a_db);
                n_inc += int'(inc) + int'(dec);
            end
            chk($sformatf("bounce%0d_a_db", len), n_adb, 0);
            chk($sformatf("bounce%0d_pulses", len), n_inc, 0);
            chk($sformatf("bounce%0d_value", len), int'(value), 0);
        end

        // Table: settled input phases, pulses counted per phase
        for (int i = 0; i < int'(NV); i++) begin
            a      = vecs[i].a;
            b      = vecs[i].b;
            n_inc  = 0;
            n_dec  = 0;
            n_both = 0;
            repeat (HOLD) begin
                tick();
                n_inc += int'(inc);
                n_dec += int'(dec);
                if (inc && dec) n_both++;
            end
            chk($sformatf("vec%0d_value", i), int'(value), int'(vecs[i].exp_value));
            chk($sformatf("vec%0d_a_db", i), int'(a_db), int'(vecs[i].a));
            chk($sformatf("vec%0d_b_db", i), int'(b_db), int'(vecs[i].b));
            chk($sformatf("vec%0d_inc_cnt", i), n_inc, vecs[i].exp_inc);
            chk($sformatf("vec%0d_dec_cnt", i), n_dec, vecs[i].exp_dec);
            chk($sformatf("vec%0d_inc_and_dec", i), n_both, 0);
        end

        // Latency from first sampled-high edge of a to the inc pulse
        lat_seen = 0;
        a = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (inc && lat_seen == 0) lat_seen = k;
            if (lat_seen != 0) break;
        end
        chk("first_inc_edge", lat_seen, int'(LAT));
        chk("latency_value", int'(value), 1);

        // Reset during rotation clears the count at the next edge
        b = 1'b1;
        repeat (5) tick();
        reset = 1'b0;
        tick();
        chk("midrot_reset_value", int'(value), 0);
        chk("midrot_reset_a_db", int'(a_db), 0);
        chk("midrot_reset_inc", int'(inc), 0);
        reset = 1'b1;
        a = 1'b0;
        b = 1'b0;
        repeat (HOLD) tick();
        chk("post_reset_value", int'(value), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
